// File: rtl/uart_pkg.sv
// Shared types and defaults for the serial receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_e;

    localparam int UART_DEF_CLKS_PER_BIT = 16;
    localparam int UART_DEF_DATA_BITS    = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level; reset value selectable
// so an idle-high line does not look like a start bit coming out of reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic theclk,
    input  logic theresetn,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge theclk or negedge theresetn) begin
        if (!theresetn) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1-style serial receiver: mid-bit sampling from a half-bit-aligned down-counter,
// with registered byte/valid, framing-error and line-break pulses.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DEF_DATA_BITS
) (
    input  logic                 theclk,
    input  logic                 theresetn,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 busy_o
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    if (((CLKS_PER_BIT % 2) != 0) || (CLKS_PER_BIT < 4)) begin : g_bad_cpb
        $error("uart_rx_deserializer: CLKS_PER_BIT must be even and >= 4");
    end

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 busy_q;
    logic                 rx_s;
    logic                 tick;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .theclk    (theclk),
        .theresetn (theresetn),
        .d_i       (rx_i),
        .q_o       (rx_s)
    );

    assign tick = (cnt_q == '0);

    always_ff @(posedge theclk or negedge theresetn) begin
        if (!theresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_s) state_d = START;
            START:   if (tick) state_d = rx_s ? IDLE : DATA;
            DATA:    if (tick && (bit_q == LAST_BIT)) state_d = STOP;
            STOP: begin
                if (tick) begin
                    // An all-zero frame with a low stop bit means the line is held low.
                    state_d = (!rx_s && (shift_q == '0)) ? BRK : IDLE;
                end
            end
            BRK:     if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) cnt_d = CNT_HALF;
            end
            START: begin
                if (tick) begin
                    cnt_d = CNT_FULL;
                    bit_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d                = CNT_FULL;
                    shift_d              = shift_q >> 1;
                    shift_d[DATA_BITS-1] = rx_s;
                    bit_d                = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                        brk_d  = (shift_q == '0);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge theclk or negedge theresetn) begin
        if (!theresetn) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
            busy_q  <= (state_q != IDLE);
        end
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign break_o     = brk_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed + randomized frames against an event-level model: each frame predicts
// which pulse appears, on which cycle, and what rx_data_o shows with it.
module tb_uart_rx_deserializer;

    localparam int CPB  = 16;
    localparam int DB   = 8;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + (DB + 1) * CPB;

    typedef struct {
        int         kind;   // 0 valid, 1 frame error, 2 frame error + break, 3 illegal mix
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       theclk = 1'b0;
    logic       theresetn = 1'b0;
    logic       rx_i = 1'b1;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, frame_err_o, break_o, busy_o;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .theclk      (theclk),
        .theresetn   (theresetn),
        .rx_i        (rx_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .frame_err_o (frame_err_o),
        .break_o     (break_o),
        .busy_o      (busy_o)
    );

    always #5 theclk = ~theclk;

    always @(posedge theclk) cyc <= cyc + 1;

    function automatic int classify(input logic v, input logic f, input logic b);
        if (v && !f && !b) return 0;
        if (!v && f && !b) return 1;
        if (!v && f && b)  return 2;
        return 3;
    endfunction

    always @(negedge theclk) begin
        if (theresetn && (rx_valid_o || frame_err_o || break_o))
            obs_q.push_back('{classify(rx_valid_o, frame_err_o, break_o), rx_data_o, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // The model: a good stop bit delivers the byte; a low stop bit keeps the old byte
    // and flags an error, plus a break when every data bit was zero.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
        int t0;
        t0 = cyc + 1;
        if (stop) begin
            exp_q.push_back('{0, d, t0 + LAT});
            last_good = d;
        end else begin
            exp_q.push_back('{(d == 8'h00) ? 2 : 1, last_good, t0 + LAT});
        end
        rx_i = 1'b0;
        repeat (CPB) @(negedge theclk);
        for (int i = 0; i < DB; i++) begin
            rx_i = d[i];
            repeat (CPB) @(negedge theclk);
        end
        rx_i = stop;
        repeat (CPB) @(negedge theclk);
        rx_i = 1'b1;
        repeat (gap) @(negedge theclk);
    endtask

    task automatic compare_events(input string tag);
        ev_t o, e;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_kind"}, 32'(o.kind), 32'(e.kind));
            chk({tag, "_data"}, 32'(o.data), 32'(e.data));
            chk({tag, "_cycle"}, 32'(o.cyc), 32'(e.cyc));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic seen_busy;
        int   t_first;
        logic [7:0] d;
        logic stop;

        // Reset state
        repeat (3) @(negedge theclk);
        chk("rst_data", 32'(rx_data_o), 32'h0);
        chk("rst_valid", 32'(rx_valid_o), 32'h0);
        chk("rst_ferr", 32'(frame_err_o), 32'h0);
        chk("rst_brk", 32'(break_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        theresetn = 1'b1;
        repeat (5) @(negedge theclk);

        // 1: single 0x55, explicit latency check
        t_first = cyc + 1;
        send_frame(8'h55, 1'b1, 2 * CPB);
        chk("t1_latency", 32'(obs_q.size() > 0 ? obs_q[0].cyc - t_first : -1), 32'(2 + 8 + 144));
        compare_events("t1");
        chk("t1_busy_idle", 32'(busy_o), 32'h0);

        // 4: bad stop bit keeps prior byte, no break
        send_frame(8'hA3, 1'b0, 2 * CPB);
        compare_events("t4");
        chk("t4_data_kept", 32'(rx_data_o), 32'h55);

        // 2: back-to-back, no idle gap
        send_frame(8'h48, 1'b1, 0);
        send_frame(8'h69, 1'b1, 0);
        send_frame(8'h0A, 1'b1, 2 * CPB);
        compare_events("t2");

        // 3: short low glitch
        rx_i = 1'b0;
        repeat (5) @(negedge theclk);
        rx_i = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy_o) seen_busy = 1'b1;
            @(negedge theclk);
        end
        for (int i = 0; i < 20 && busy_o; i++) @(negedge theclk);
        chk("t3_busy_seen", 32'(seen_busy), 32'h1);
        chk("t3_busy_clear", 32'(busy_o), 32'h0);
        repeat (CPB) @(negedge theclk);
        compare_events("t3");

        // 5: line break of 400 clocks, then a normal frame
        exp_q.push_back('{2, last_good, cyc + 1 + LAT});
        rx_i = 1'b0;
        repeat (399) @(negedge theclk);
        chk("t5_busy_held", 32'(busy_o), 32'h1);
        @(negedge theclk);
        rx_i = 1'b1;
        repeat (6) @(negedge theclk);
        chk("t5_busy_released", 32'(busy_o), 32'h0);
        compare_events("t5_brk");
        repeat (CPB) @(negedge theclk);
        send_frame(8'h31, 1'b1, 2 * CPB);
        compare_events("t5_frame");
        chk("t5_data", 32'(rx_data_o), 32'h31);

        // 6: reset during data bit 4 of 0xFF
        rx_i = 1'b0;
        repeat (CPB) @(negedge theclk);
        rx_i = 1'b1;
        repeat (4 * CPB + HALF) @(negedge theclk);
        theresetn = 1'b0;
        @(negedge theclk);
        chk("t6_rst_data", 32'(rx_data_o), 32'h0);
        chk("t6_rst_pulses", 32'({rx_valid_o, frame_err_o, break_o}), 32'h0);
        chk("t6_rst_busy", 32'(busy_o), 32'h0);
        repeat (8) @(negedge theclk);
        theresetn = 1'b1;
        last_good = 8'h00;
        repeat (6 * CPB) @(negedge theclk);
        send_frame(8'h12, 1'b1, 2 * CPB);
        compare_events("t6");

        // Randomized frames, gaps and stop-bit faults
        for (int n = 0; n < 16; n++) begin
            d    = 8'($urandom);
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop, stop ? $urandom_range(0, 3 * CPB) : $urandom_range(CPB, 3 * CPB));
        end
        repeat (2 * CPB) @(negedge theclk);
        compare_events("rand");
        chk("rand_last_data", 32'(rx_data_o), 32'(last_good));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
